// File: rtl/wb_axi_pkg.sv
// Shared types and AXI encodings for the Wishbone-to-AXI DDR bridge.
package wb_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B         = 3'd3;
  localparam int         AXI_RESP_SLVERR_BIT = 1;

  // Places the 32-bit Wishbone byte selects on the addressed half of the 64-bit beat.
  function automatic logic [7:0] lane_strobe(input logic lane, input logic [3:0] sel);
    return lane ? {sel, 4'h0} : {4'h0, sel};
  endfunction

endpackage

// File: rtl/wb_axi_ddr_bridge.sv
// Wishbone B4 classic 32-bit slave to single-beat 64-bit AXI4 master feeding the DDR user port.
// One transaction in flight; every Wishbone access becomes exactly one AXI beat.
module wb_axi_ddr_bridge
  import wb_axi_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 27,
  parameter int                  ID_WIDTH   = 1,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  // Wishbone slave
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  // AXI4 write address
  output logic [ID_WIDTH-1:0]   o_awid,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  output logic [7:0]            o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  // AXI4 write data
  output logic [63:0]           o_wdata,
  output logic [7:0]            o_wstrb,
  output logic                  o_wlast,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  // AXI4 write response
  input  logic [ID_WIDTH-1:0]   i_bid,
  input  logic [1:0]            i_bresp,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  // AXI4 read address
  output logic [ID_WIDTH-1:0]   o_arid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  // AXI4 read data
  input  logic [ID_WIDTH-1:0]   i_rid,
  input  logic [63:0]           i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  input  logic                  i_rvalid,
  output logic                  o_rready
);

  state_t                state, state_next;
  logic [ADDR_WIDTH-4:0] req_addr_hi;
  logic                  req_lane;
  logic [31:0]           req_dat;
  logic [3:0]            req_sel;
  logic                  aw_done, w_done, cyc_lost;
  logic                  accept, aw_hs, w_hs;
  logic                  resp_done, resp_err, resp_keep;

  // The ack/err cycle is excluded so a master still holding stb is not accepted twice.
  assign accept    = (state == IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
  assign aw_hs     = o_awvalid && i_awready;
  assign w_hs      = o_wvalid && i_wready;
  assign resp_keep = wb_cyc_i && !cyc_lost;

  assign o_awid    = AXI_ID;
  assign o_awaddr  = {req_addr_hi, 3'b000};
  assign o_awlen   = 8'd0;
  assign o_awsize  = AXI_SIZE_8B;
  assign o_awburst = AXI_BURST_INCR;
  assign o_wdata   = {req_dat, req_dat};
  assign o_wstrb   = lane_strobe(req_lane, req_sel);
  assign o_wlast   = 1'b1;
  assign o_arid    = AXI_ID;
  assign o_araddr  = {req_addr_hi, 3'b000};
  assign o_arlen   = 8'd0;
  assign o_arsize  = AXI_SIZE_8B;
  assign o_arburst = AXI_BURST_INCR;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves a latch.
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = wb_we_i ? WADDR : RADDR;
      WADDR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WRESP;
      WRESP:   if (i_bvalid) state_next = IDLE;
      RADDR:   if (i_arready) state_next = RDATA;
      RDATA:   if (i_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    o_arvalid = 1'b0;
    o_rready  = 1'b0;
    resp_done = 1'b0;
    resp_err  = 1'b0;
    case (state)
      WADDR: begin
        o_awvalid = !aw_done;
        o_wvalid  = !w_done;
      end
      WRESP: begin
        o_bready  = 1'b1;
        resp_done = i_bvalid;
        resp_err  = i_bresp[AXI_RESP_SLVERR_BIT];
      end
      RADDR: o_arvalid = 1'b1;
      RDATA: begin
        o_rready  = 1'b1;
        resp_done = i_rvalid;
        resp_err  = i_rresp[AXI_RESP_SLVERR_BIT] || !i_rlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      cyc_lost <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= resp_done && !resp_err && resp_keep;
      wb_err_o <= resp_done && resp_err && resp_keep;
      if (accept) begin
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        cyc_lost <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
        // An abandoned cycle still finishes on AXI but must not ack a later master.
        if (state != IDLE && !wb_cyc_i) cyc_lost <= 1'b1;
      end
      if (state == RDATA && i_rvalid)
        wb_dat_o <= req_lane ? i_rdata[63:32] : i_rdata[31:0];
    end
  end

  // NOTE: request payload needs no reset; it is only observed once a request has loaded it.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr_hi <= wb_adr_i[ADDR_WIDTH-1:3];
      req_lane    <= wb_adr_i[2];
      req_dat     <= wb_dat_i;
      req_sel     <= wb_sel_i;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{wb_adr_i[1:0], i_bid, i_rid, i_bresp, i_rresp};

endmodule

// File: tb/tb_wb_axi_ddr_bridge.sv
// Directed bench for wb_axi_ddr_bridge: a vector table drives a Wishbone master and a
// delay-configurable AXI slave; reset-in-flight is a hand-written sequence.
module tb_wb_axi_ddr_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [0:0]  o_awid, o_arid, i_bid, i_rid;
  logic [26:0] o_awaddr, o_araddr;
  logic [7:0]  o_awlen, o_arlen, o_wstrb;
  logic [2:0]  o_awsize, o_arsize;
  logic [1:0]  o_awburst, o_arburst, i_bresp, i_rresp;
  logic        o_awvalid, i_awready, o_wlast, o_wvalid, i_wready;
  logic        i_bvalid, o_bready, o_arvalid, i_arready;
  logic [63:0] o_wdata, i_rdata;
  logic        i_rlast, i_rvalid, o_rready;

  always #5 clk = ~clk;

  wb_axi_ddr_bridge dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  typedef struct {
    logic        we;
    logic [26:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          aw_dly, w_dly, ar_dly, resp_dly;
    logic [1:0]  resp;
    logic        rlast;
    logic [63:0] rdata;
    logic        drop_cyc;
    logic [26:0] exp_addr;
    logic [7:0]  exp_wstrb;
    logic [31:0] exp_dat;
    int          exp_ack, exp_err, exp_lat;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the most recent transaction.
  int          r_ack, r_err, r_lat, r_first, r_awvc, r_wvc, r_arvc;
  logic        r_done, r_resp_hs, r_wlast;
  logic [26:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic [31:0] r_dat;
  logic [12:0] r_const;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
    i_bvalid  = 1'b0; i_rvalid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int   c, end_c, b_cnt, r_cnt;
    logic aw_hs, w_hs, ar_hs, dropped;
    r_ack = 0; r_err = 0; r_lat = 0; r_first = 0; r_awvc = 0; r_wvc = 0; r_arvc = 0;
    r_done = 1'b0; r_resp_hs = 1'b0; r_wlast = 1'b0; r_addr = '0; r_wdata = '0;
    r_wstrb = '0; r_dat = '0; r_const = '0;
    aw_hs = 1'b0; w_hs = 1'b0; ar_hs = 1'b0; dropped = 1'b0;
    b_cnt = 0; r_cnt = 0; end_c = 0;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
    wb_adr_i = v.adr; wb_dat_i = v.dat; wb_sel_i = v.sel;
    i_bresp = v.resp; i_rresp = v.resp; i_rlast = v.rlast; i_rdata = v.rdata;
    c = 0;
    while (!(r_done && c >= end_c + 3) && c < 60) begin
      @(negedge clk);
      c++;
      if (wb_ack_o) begin r_ack++; if (r_lat == 0) r_lat = c; r_dat = wb_dat_o; end
      if (wb_err_o) begin r_err++; if (r_lat == 0) r_lat = c; end
      if ((wb_ack_o || wb_err_o) && !r_done) begin
        r_done = 1'b1; end_c = c; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      if (r_first == 0 && (o_awvalid || o_wvalid || o_arvalid)) r_first = c;
      if (o_awvalid) begin
        r_awvc++; r_addr = o_awaddr; r_const = {o_awid, o_awlen, o_awsize, o_awburst};
      end
      if (o_wvalid) begin r_wvc++; r_wdata = o_wdata; r_wstrb = o_wstrb; r_wlast = o_wlast; end
      if (o_arvalid) begin
        r_arvc++; r_addr = o_araddr; r_const = {o_arid, o_arlen, o_arsize, o_arburst};
      end
      if (v.drop_cyc && o_rready && !dropped) begin
        dropped = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
      // Slave: ready after the configured number of waiting valid cycles.
      i_awready = o_awvalid && (r_awvc > v.aw_dly);
      i_wready  = o_wvalid  && (r_wvc  > v.w_dly);
      i_arready = o_arvalid && (r_arvc > v.ar_dly);
      if (i_awready) aw_hs = 1'b1;
      if (i_wready)  w_hs  = 1'b1;
      if (i_arready) ar_hs = 1'b1;
      i_bvalid = 1'b0;
      if (o_bready && aw_hs && w_hs && !r_resp_hs) begin
        i_bvalid = (b_cnt >= v.resp_dly); b_cnt++;
        if (i_bvalid) r_resp_hs = 1'b1;
      end
      i_rvalid = 1'b0;
      if (o_rready && ar_hs && !r_resp_hs) begin
        i_rvalid = (r_cnt >= v.resp_dly); r_cnt++;
        if (i_rvalid) r_resp_hs = 1'b1;
      end
      if (v.drop_cyc && r_resp_hs && !r_done) begin r_done = 1'b1; end_c = c; end
    end
    @(negedge clk);
    slave_idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    check($sformatf("v%0d_done", i), 64'(r_done), 64'd1);
    check($sformatf("v%0d_first_valid", i), 64'(r_first), 64'd1);
    check($sformatf("v%0d_addr", i), 64'(r_addr), 64'(v.exp_addr));
    check($sformatf("v%0d_axi_const", i), 64'(r_const), 64'({1'b0, 8'h00, 3'd3, 2'b01}));
    check($sformatf("v%0d_ack_cnt", i), 64'(r_ack), 64'(v.exp_ack));
    check($sformatf("v%0d_err_cnt", i), 64'(r_err), 64'(v.exp_err));
    if (v.exp_lat != 0) check($sformatf("v%0d_latency", i), 64'(r_lat), 64'(v.exp_lat));
    if (v.we) begin
      check($sformatf("v%0d_wstrb", i), 64'(r_wstrb), 64'(v.exp_wstrb));
      check($sformatf("v%0d_wdata", i), r_wdata, {v.dat, v.dat});
      check($sformatf("v%0d_wlast", i), 64'(r_wlast), 64'd1);
      check($sformatf("v%0d_aw_valid_cycles", i), 64'(r_awvc), 64'(v.aw_dly + 1));
      check($sformatf("v%0d_w_valid_cycles", i), 64'(r_wvc), 64'(v.w_dly + 1));
    end else begin
      check($sformatf("v%0d_ar_valid_cycles", i), 64'(r_arvc), 64'(v.ar_dly + 1));
      if (v.exp_ack != 0) check($sformatf("v%0d_rdata", i), 64'(r_dat), 64'(v.exp_dat));
    end
    if (v.drop_cyc) check($sformatf("v%0d_r_consumed", i), 64'(r_resp_hs), 64'd1);
  endtask

  initial begin
    // we adr dat sel aw w ar rsp resp rlast rdata drop | addr wstrb dat ack err lat
    vecs[0] = '{1'b1, 27'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 1'b1, 64'h0, 1'b0,
                27'h100, 8'h0F, 32'h0, 1, 0, 3};
    vecs[1] = '{1'b1, 27'h104, 32'hCAFEF00D, 4'h3, 3, 0, 0, 0, 2'b00, 1'b1, 64'h0, 1'b0,
                27'h100, 8'h30, 32'h0, 1, 0, 6};
    vecs[2] = '{1'b0, 27'h10C, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 1'b1, 64'h11223344_55667788,
                1'b0, 27'h108, 8'h00, 32'h11223344, 1, 0, 3};
    vecs[3] = '{1'b0, 27'h110, 32'h0, 4'hF, 0, 0, 0, 0, 2'b10, 1'b1, 64'hFFFF0000_FFFF0000,
                1'b0, 27'h110, 8'h00, 32'h0, 0, 1, 3};
    vecs[4] = '{1'b0, 27'h200, 32'h0, 4'hF, 0, 0, 2, 1, 2'b00, 1'b1, 64'hAABBCCDD_01234567,
                1'b0, 27'h200, 8'h00, 32'h01234567, 1, 0, 6};
    vecs[5] = '{1'b1, 27'h0FC, 32'h12345678, 4'h0, 0, 2, 0, 0, 2'b10, 1'b1, 64'h0, 1'b0,
                27'h0F8, 8'h00, 32'h0, 0, 1, 5};
    vecs[6] = '{1'b1, 27'h7FFFFF8, 32'hA5A5_5A5A, 4'h9, 0, 0, 0, 2, 2'b00, 1'b1, 64'h0, 1'b0,
                27'h7FFFFF8, 8'h09, 32'h0, 1, 0, 5};
    vecs[7] = '{1'b0, 27'h018, 32'h0, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0, 64'h01020304_05060708,
                1'b0, 27'h018, 8'h00, 32'h0, 0, 1, 3};
    vecs[8] = '{1'b0, 27'h10C, 32'h0, 4'hF, 0, 0, 0, 2, 2'b00, 1'b1, 64'h99887766_55443322,
                1'b1, 27'h108, 8'h00, 32'h0, 0, 0, 0};

    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    i_bid = '0; i_rid = '0; i_bresp = '0; i_rresp = '0; i_rlast = 1'b1; i_rdata = '0;
    slave_idle();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, wb_ack_o, wb_err_o}), 64'd0);
    check("reset_dat", 64'(wb_dat_o), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      run_txn(vecs[i]);
      check_vec(i, vecs[i]);
    end

    // Reset while waiting for the write response.
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 27'h040; wb_dat_i = 32'h0BAD_F00D; wb_sel_i = 4'hF;
    i_awready = 1'b1; i_wready = 1'b1;
    for (int k = 0; k < 20 && !o_bready; k++) @(negedge clk);
    check("rst_reached_wresp", 64'(o_bready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs",
          64'({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, wb_ack_o, wb_err_o}), 64'd0);
    check("rst_mid_dat", 64'(wb_dat_o), 64'd0);
    rst = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    slave_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_ack_%0d", k), 64'({wb_ack_o, wb_err_o, o_awvalid, o_bready}), 64'd0);
    end
    run_txn(vecs[0]);
    check_vec(100, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
